// File: rtl/detector_acq_ctrl_if.sv
// AXI4-Stream style event-word channel from the acquisition sequencer.
// A word transfers on every clock edge where tvalid and tready are both high;
// while tvalid is high and tready is low, the master holds tdata and tuser stable.
interface detector_acq_ctrl_if;
    logic [63:0] tdata;
    logic [6:0]  tuser;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/detector_acq_ctrl.sv
// Detector acquisition sequencer: arm, trigger on the first masked hit, OR hits
// over a coincidence window, emit one hit-mask word, then hold off before re-arming.
module detector_acq_ctrl #(
    parameter int CNTR_WIDTH = 32,
    parameter int HOLD_WIDTH = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [63:0]           det_data,
    input  logic                  cfg_enable,
    input  logic [63:0]           cfg_mask,
    input  logic [7:0]            cfg_window,
    input  logic [HOLD_WIDTH-1:0] cfg_holdoff,
    input  logic                  cnt_clear,
    detector_acq_ctrl_if.master   m_axis,
    output logic [2:0]            sts_state,
    output logic [CNTR_WIDTH-1:0] sts_events,
    output logic [CNTR_WIDTH-1:0] sts_drops
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_WINDOW  = 3'd2;
    localparam logic [2:0] S_OUTPUT  = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic [2:0]            state;
    logic [63:0]           data_reg;
    logic [7:0]            win_lat;
    logic [7:0]            win_cntr;
    logic [HOLD_WIDTH-1:0] hold_lat;
    logic [HOLD_WIDTH-1:0] hold_cntr;

    logic [63:0] hits;
    logic [63:0] acc;
    logic [6:0]  acc_pop;
    logic        handshake;
    logic        hit_any;

    assign hits      = det_data & cfg_mask;
    assign hit_any   = |hits;
    assign acc       = data_reg | hits;
    assign handshake = m_axis.tvalid & m_axis.tready;
    assign sts_state = state;

    always_comb begin
        acc_pop = 7'd0;
        for (int i = 0; i < 64; i++) begin
            acc_pop = acc_pop + 7'(acc[i]);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= S_IDLE;
            data_reg      <= 64'd0;
            win_lat       <= 8'd0;
            win_cntr      <= 8'd0;
            hold_lat      <= '0;
            hold_cntr     <= '0;
            m_axis.tdata  <= 64'd0;
            m_axis.tuser  <= 7'd0;
            m_axis.tvalid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_enable) state <= S_ARMED;
                end
                S_ARMED: begin
                    if (!cfg_enable) begin
                        state <= S_IDLE;
                    end else if (hit_any) begin
                        data_reg <= hits;
                        win_lat  <= cfg_window;
                        hold_lat <= cfg_holdoff;
                        win_cntr <= 8'd0;
                        state    <= S_WINDOW;
                    end
                end
                S_WINDOW: begin
                    // The word includes this cycle's hits, so it is built from acc, not data_reg.
                    data_reg <= acc;
                    win_cntr <= win_cntr + 8'd1;
                    if (win_cntr >= win_lat) begin
                        m_axis.tdata  <= acc;
                        m_axis.tuser  <= acc_pop;
                        m_axis.tvalid <= 1'b1;
                        state         <= S_OUTPUT;
                    end
                end
                S_OUTPUT: begin
                    if (handshake) begin
                        m_axis.tvalid <= 1'b0;
                        if (hold_lat == '0) begin
                            state <= cfg_enable ? S_ARMED : S_IDLE;
                        end else begin
                            hold_cntr <= HOLD_WIDTH'(1);
                            state     <= S_HOLDOFF;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (hold_cntr >= hold_lat) begin
                        state <= cfg_enable ? S_ARMED : S_IDLE;
                    end else begin
                        hold_cntr <= hold_cntr + HOLD_WIDTH'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Events wrap; drops saturate so a long dead period never reads as a small count.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sts_events <= '0;
            sts_drops  <= '0;
        end else if (cnt_clear) begin
            sts_events <= '0;
            sts_drops  <= '0;
        end else begin
            if (handshake) sts_events <= sts_events + CNTR_WIDTH'(1);
            if ((state == S_OUTPUT || state == S_HOLDOFF) && hit_any && (sts_drops != '1))
                sts_drops <= sts_drops + CNTR_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_detector_acq_ctrl.sv
// Bench for detector_acq_ctrl: table-driven single events plus hand-written
// sequences for backpressure, hold-off, enable, reset and counter corners.
module tb_detector_acq_ctrl;
    localparam int CW = 4;
    localparam int HW = 16;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMED   = 3'd1;
    localparam logic [2:0] S_WINDOW  = 3'd2;
    localparam logic [2:0] S_OUTPUT  = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;

    logic          aclk;
    logic          areset;
    logic [63:0]   det_data;
    logic          cfg_enable;
    logic [63:0]   cfg_mask;
    logic [7:0]    cfg_window;
    logic [HW-1:0] cfg_holdoff;
    logic          cnt_clear;
    logic [2:0]    sts_state;
    logic [CW-1:0] sts_events;
    logic [CW-1:0] sts_drops;

    detector_acq_ctrl_if axis ();

    detector_acq_ctrl #(.CNTR_WIDTH(CW), .HOLD_WIDTH(HW)) dut (
        .aclk        (aclk),
        .areset      (areset),
        .det_data    (det_data),
        .cfg_enable  (cfg_enable),
        .cfg_mask    (cfg_mask),
        .cfg_window  (cfg_window),
        .cfg_holdoff (cfg_holdoff),
        .cnt_clear   (cnt_clear),
        .m_axis      (axis.master),
        .sts_state   (sts_state),
        .sts_events  (sts_events),
        .sts_drops   (sts_drops)
    );

    // clock / reset
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    int checks = 0;
    int failures = 0;
    logic [70:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_counters();
        cnt_clear = 1'b1;
        step();
        cnt_clear = 1'b0;
    endtask

    // scoreboard: every accepted word is compared against the oldest expectation
    always @(negedge aclk) begin
        if (!areset && axis.tvalid && axis.tready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", axis.tdata, 64'd0);
                if (axis.tdata === 64'd0) begin
                    failures++;
                    $display("FAIL unexpected_word actual=word required=none");
                end
            end else begin
                logic [70:0] e;
                e = exp_q.pop_front();
                chk("tdata", axis.tdata, e[70:7]);
                chk("tuser", {57'd0, axis.tuser}, {57'd0, e[6:0]});
            end
        end
    end

    // Called at #1 after an edge with the DUT in ARMED; that cycle is the trigger cycle.
    task automatic run_event(input string name, input logic [63:0] d0, input logic [63:0] d1,
                             input int d1_off, input int exp_lat, input logic [63:0] exp_data,
                             input logic [6:0] exp_user, input int stall, input bit clr);
        int lat;
        lat = 0;
        axis.tready = (stall == 0);
        det_data = d0;
        exp_q.push_back({exp_data, exp_user});
        for (int k = 1; k <= 300; k++) begin
            step();
            if (axis.tvalid) begin
                lat = k;
                break;
            end
            det_data = (k == d1_off) ? d1 : 64'd0;
        end
        det_data = 64'd0;
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
        if (lat == 0) return;
        if (stall > 0) begin
            det_data = 64'd1;
            for (int s = 1; s < stall; s++) begin
                step();
                chk({name, "_hold_tdata"}, axis.tdata, exp_data);
            end
            step();
            chk({name, "_hold_state"}, 64'(sts_state), 64'(S_OUTPUT));
            det_data = 64'd0;
        end
        axis.tready = 1'b1;
        cnt_clear = clr;
        step();
        cnt_clear = 1'b0;
    endtask

    typedef struct {
        logic [63:0] mask;
        logic [7:0]  win;
        logic [63:0] d0;
        logic [63:0] d1;
        int          d1_off;
        logic [63:0] exp_data;
        logic [6:0]  exp_user;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int rises, last_rise, hold_run, armed_run, lat;
        bit seen_hold, prev_tv;

        vecs[0] = '{ONES, 8'd3, 64'h1, 64'h100, 2, 64'h101, 7'd2};
        vecs[1] = '{ONES, 8'd0, MSB, 64'h1, 1, MSB | 64'h1, 7'd2};
        vecs[2] = '{64'hFF, 8'd1, 64'h1FF, 64'h300, 2, 64'hFF, 7'd8};
        vecs[3] = '{64'h0000_FFFF_0000_0000, 8'd2, 64'h1_0000_0000, ONES, 3,
                    64'h0000_FFFF_0000_0000, 7'd16};
        vecs[4] = '{ONES, 8'd7, ONES, 64'd0, 0, ONES, 7'd64};
        vecs[5] = '{ONES, 8'd255, 64'h2, 64'h4, 256, 64'h6, 7'd2};

        areset = 1'b1;
        det_data = 64'd0;
        cfg_enable = 1'b0;
        cfg_mask = ONES;
        cfg_window = 8'd0;
        cfg_holdoff = '0;
        cnt_clear = 1'b0;
        axis.tready = 1'b1;
        #1;
        chk("reset_state", 64'(sts_state), 64'(S_IDLE));
        chk("reset_tvalid", 64'(axis.tvalid), 64'd0);
        chk("reset_tdata", axis.tdata, 64'd0);
        chk("reset_tuser", 64'(axis.tuser), 64'd0);
        chk("reset_events", 64'(sts_events), 64'd0);
        chk("reset_drops", 64'(sts_drops), 64'd0);
        step();
        step();
        areset = 1'b0;
        step();
        chk("idle_hold", 64'(sts_state), 64'(S_IDLE));
        cfg_enable = 1'b1;
        step();
        chk("arm", 64'(sts_state), 64'(S_ARMED));

        // hits outside the mask never trigger
        cfg_mask = 64'h0000_FFFF_0000_0000;
        det_data = 64'h0000_0000_FFFF_FFFF;
        for (int i = 0; i < 5; i++) step();
        det_data = 64'd0;
        chk("masked_no_trigger", 64'(sts_state), 64'(S_ARMED));

        foreach (vecs[i]) begin
            cfg_mask = vecs[i].mask;
            cfg_window = vecs[i].win;
            run_event($sformatf("vec%0d", i), vecs[i].d0, vecs[i].d1, vecs[i].d1_off,
                      int'(vecs[i].win) + 2, vecs[i].exp_data, vecs[i].exp_user, 0, 1'b0);
            chk($sformatf("vec%0d_rearm", i), 64'(sts_state), 64'(S_ARMED));
        end
        chk("table_events", 64'(sts_events), 64'd6);
        chk("table_drops", 64'(sts_drops), 64'd0);

        // backpressure: word held, each stalled hit cycle is a drop, drops saturate
        cfg_mask = ONES;
        cfg_window = 8'd0;
        clear_counters();
        run_event("stall", MSB, 64'd0, 0, 2, MSB, 7'd1, 10, 1'b0);
        chk("stall_drops", 64'(sts_drops), 64'd10);
        chk("stall_events", 64'(sts_events), 64'd1);
        chk("stall_rearm", 64'(sts_state), 64'(S_ARMED));
        run_event("stall2", MSB, 64'd0, 0, 2, MSB, 7'd1, 10, 1'b0);
        chk("drops_saturate", 64'(sts_drops), 64'd15);

        // hold-off with continuous hits: 1 output + 5 hold-off drop cycles per event
        cfg_window = 8'd1;
        cfg_holdoff = HW'(5);
        clear_counters();
        rises = 0; last_rise = -1; hold_run = 0; armed_run = 0;
        seen_hold = 1'b0; prev_tv = 1'b0;
        det_data = 64'd1;
        for (int c = 0; c < 32; c++) begin
            step();
            if (sts_state == S_HOLDOFF) begin
                hold_run++;
            end else if (hold_run > 0) begin
                chk("holdoff_len", 64'(hold_run), 64'd5);
                hold_run = 0;
                seen_hold = 1'b1;
            end
            if (sts_state == S_ARMED) begin
                armed_run++;
            end else if (armed_run > 0) begin
                if (seen_hold) chk("rearm_len", 64'(armed_run), 64'd1);
                armed_run = 0;
            end
            if (axis.tvalid && !prev_tv) begin
                exp_q.push_back({64'd1, 7'd1});
                if (last_rise >= 0) chk("event_spacing", 64'(c - last_rise), 64'd9);
                last_rise = c;
                rises++;
            end
            prev_tv = axis.tvalid;
            det_data = (rises < 3) ? 64'd1 : 64'd0;
        end
        chk("holdoff_events", 64'(sts_events), 64'd3);
        chk("holdoff_drops", 64'(sts_drops), 64'd12);
        chk("holdoff_final", 64'(sts_state), 64'(S_ARMED));
        cfg_holdoff = '0;

        // enable dropped mid-window: word still delivered, then IDLE
        cfg_window = 8'd3;
        det_data = 64'h10;
        exp_q.push_back({64'h10, 7'd1});
        step();
        det_data = 64'd0;
        cfg_enable = 1'b0;
        lat = 0;
        for (int k = 2; k <= 20; k++) begin
            step();
            if (axis.tvalid) begin
                lat = k;
                break;
            end
        end
        chk("disable_latency", 64'(lat), 64'd5);
        step();
        chk("disable_idle", 64'(sts_state), 64'(S_IDLE));

        // enable low together with a hit in ARMED: back to IDLE, no event
        cfg_enable = 1'b1;
        step();
        chk("rearm_from_idle", 64'(sts_state), 64'(S_ARMED));
        cfg_enable = 1'b0;
        det_data = 64'd1;
        step();
        chk("disable_beats_hit", 64'(sts_state), 64'(S_IDLE));
        det_data = 64'd0;
        for (int i = 0; i < 3; i++) step();
        chk("disable_no_word", 64'(axis.tvalid), 64'd0);

        // asynchronous reset while a word is pending
        cfg_enable = 1'b1;
        step();
        cfg_window = 8'd0;
        axis.tready = 1'b0;
        det_data = 64'h4;
        step();
        det_data = 64'd0;
        step();
        chk("pre_reset_tvalid", 64'(axis.tvalid), 64'd1);
        #3;
        areset = 1'b1;
        #1;
        chk("reset_mid_tvalid", 64'(axis.tvalid), 64'd0);
        chk("reset_mid_state", 64'(sts_state), 64'(S_IDLE));
        step();
        areset = 1'b0;
        axis.tready = 1'b1;
        chk("reset_mid_events", 64'(sts_events), 64'd0);
        step();
        step();
        chk("reset_rearm", 64'(sts_state), 64'(S_ARMED));

        // counter corners: saturated drops, clear coincident with a handshake, wrap
        for (int i = 0; i < 13; i++) run_event("quick", 64'h1, 64'd0, 0, 2, 64'h1, 7'd1, 0, 1'b0);
        run_event("sat", 64'h1, 64'd0, 0, 2, 64'h1, 7'd1, 16, 1'b0);
        chk("sat_events", 64'(sts_events), 64'd14);
        chk("sat_drops", 64'(sts_drops), 64'd15);
        run_event("clr", 64'h1, 64'd0, 0, 2, 64'h1, 7'd1, 2, 1'b1);
        chk("clr_events", 64'(sts_events), 64'd0);
        chk("clr_drops", 64'(sts_drops), 64'd0);
        for (int i = 0; i < 16; i++) run_event("wrap", 64'h1, 64'd0, 0, 2, 64'h1, 7'd1, 0, 1'b0);
        chk("events_wrap", 64'(sts_events), 64'd0);

        step();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
